buffer_read_scheduler: RTL and testbench

- Sequences all reads from the FPGA2 rx 16-bit sample buffer.
- Shares the buffer read port between two requesters:
  - Port 0, stream: in-order burst consumer. Its reads advance the buffer's datastarting.
  - Port 1, peek: single-word random read of unconsumed data. Never advances datastarting.
- Sits between the buffer and the downstream summary/forwarding logic, and owns givedataout/addressofdata.

---
 rtl/buffer_read_scheduler_if.sv | 41 ++++
 rtl/buffer_read_scheduler.sv | 158 +++++++++++++++
 tb/tb_buffer_read_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_read_scheduler_if.sv
// Requester, result and buffer read-port signals of the rx sample buffer read scheduler.
// The master side drives requests and buffer responses; the scheduler sits on the slave side.
interface buffer_read_scheduler_if #(
  parameter int CNTW = 16
);
  logic            req0;
  logic [CNTW-1:0] len0;
  logic            gnt0;
  logic            out0_valid;
  logic [15:0]     out0_data;
  logic            done0;
  logic            short0;
  logic [CNTW-1:0] count0;

  logic            req1;
  logic [23:0]     addr1;
  logic            gnt1;
  logic            out1_valid;
  logic [15:0]     out1_data;
  logic            done1;
  logic            err1;

  logic            givedataout;
  logic [23:0]     addressofdata;
  logic [23:0]     datastarting;
  logic [23:0]     dataend;
  logic            buffervalidout;
  logic [15:0]     bufferdataout;

  modport master (
    output req0, len0, req1, addr1, datastarting, dataend, buffervalidout, bufferdataout,
    input  gnt0, out0_valid, out0_data, done0, short0, count0,
    input  gnt1, out1_valid, out1_data, done1, err1, givedataout, addressofdata
  );

  modport slave (
    input  req0, len0, req1, addr1, datastarting, dataend, buffervalidout, bufferdataout,
    output gnt0, out0_valid, out0_data, done0, short0, count0,
    output gnt1, out1_valid, out1_data, done1, err1, givedataout, addressofdata
  );
endinterface

// File: rtl/buffer_read_scheduler.sv
// Shares the rx sample buffer read port between an in-order stream burst port (0)
// and a non-consuming single-word peek port (1). States: IDLE arbitrate | STREAM burst reads
// | PEEK one range-checked read | DRAIN wait for the last return, then pulse done.
module buffer_read_scheduler #(
  parameter int STALL_LIMIT = 1024,
  parameter int CNTW        = 16
) (
  input logic                    clock,
  input logic                    reset,
  buffer_read_scheduler_if.slave bus
);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, PEEK, DRAIN} state_t;

  state_t          state;
  logic            last;
  logic            port;
  logic [23:0]     rd_ptr;
  logic [23:0]     peek_addr;
  logic [CNTW-1:0] rem;
  logic [SW-1:0]   stall;
  logic            tag_valid;
  logic            tag_port;

  logic            gnt0_q, gnt1_q, done0_q, done1_q, short0_q, err1_q;
  logic            out0_valid_q, out1_valid_q, give_q;
  logic [15:0]     out0_data_q, out1_data_q;
  logic [CNTW-1:0] count0_q;
  logic [23:0]     addr_q;

  logic [23:0]     level;
  logic [23:0]     off;
  logic [SW-1:0]   stall_nxt;

  assign level     = bus.dataend - rd_ptr;
  assign off       = peek_addr - rd_ptr;
  assign stall_nxt = stall + SW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      port         <= 1'b0;
      rd_ptr       <= '0;
      peek_addr    <= '0;
      rem          <= '0;
      stall        <= '0;
      tag_valid    <= 1'b0;
      tag_port     <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      short0_q     <= 1'b0;
      err1_q       <= 1'b0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      give_q       <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      count0_q     <= '0;
      addr_q       <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      give_q  <= 1'b0;

      // Read latency is one cycle, so the tag simply trails the strobe.
      tag_valid    <= give_q;
      tag_port     <= port;
      out0_valid_q <= bus.buffervalidout & tag_valid & ~tag_port;
      out1_valid_q <= bus.buffervalidout & tag_valid & tag_port;
      if (bus.buffervalidout && tag_valid) begin
        if (!tag_port) begin
          out0_data_q <= bus.bufferdataout;
          count0_q    <= count0_q + CNTW'(1);
        end else begin
          out1_data_q <= bus.bufferdataout;
        end
      end

      case (state)
        IDLE: begin
          rd_ptr <= bus.datastarting;
          if (bus.req0 && (!bus.req1 || last)) begin
            gnt0_q   <= 1'b1;
            last     <= 1'b0;
            port     <= 1'b0;
            rem      <= bus.len0;
            count0_q <= '0;
            short0_q <= 1'b0;
            stall    <= '0;
            state    <= STREAM;
          end else if (bus.req1) begin
            gnt1_q    <= 1'b1;
            last      <= 1'b1;
            port      <= 1'b1;
            peek_addr <= bus.addr1;
            err1_q    <= 1'b0;
            state     <= PEEK;
          end
        end
        STREAM: begin
          if (rem == '0) begin
            state <= DRAIN;
          end else if (level != '0) begin
            give_q <= 1'b1;
            addr_q <= rd_ptr;
            rd_ptr <= rd_ptr + 24'd1;
            rem    <= rem - CNTW'(1);
            stall  <= '0;
          end else begin
            stall <= stall_nxt;
            if (stall_nxt == SW'(STALL_LIMIT)) begin
              short0_q <= 1'b1;
              state    <= DRAIN;
            end
          end
        end
        PEEK: begin
          // Offset 0 is the stream head; reading it would consume the word.
          if (off != '0 && off < level) begin
            give_q <= 1'b1;
            addr_q <= peek_addr;
          end else begin
            err1_q <= 1'b1;
          end
          state <= DRAIN;
        end
        DRAIN: begin
          if (!give_q && !tag_valid) begin
            if (port) done1_q <= 1'b1;
            else      done0_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0          = gnt0_q;
  assign bus.out0_valid    = out0_valid_q;
  assign bus.out0_data     = out0_data_q;
  assign bus.done0         = done0_q;
  assign bus.short0        = short0_q;
  assign bus.count0        = count0_q;
  assign bus.gnt1          = gnt1_q;
  assign bus.out1_valid    = out1_valid_q;
  assign bus.out1_data     = out1_data_q;
  assign bus.done1         = done1_q;
  assign bus.err1          = err1_q;
  assign bus.givedataout   = give_q;
  assign bus.addressofdata = addr_q;
endmodule

// File: tb/tb_buffer_read_scheduler.sv
// Directed bench for buffer_read_scheduler: stream bursts, stall/timeout, peek range,
// round-robin arbitration and async reset, against a 1-cycle-latency buffer model.
module tb_buffer_read_scheduler;
  logic clock;
  logic reset;

  buffer_read_scheduler_if #(.CNTW(16)) bus ();

  buffer_read_scheduler #(.STALL_LIMIT(16), .CNTW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_data(input logic [23:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.buffervalidout <= 1'b0;
      bus.bufferdataout  <= '0;
    end else begin
      bus.buffervalidout <= bus.givedataout;
      bus.bufferdataout  <= bus.givedataout ? exp_data(bus.addressofdata) : 16'h0;
    end
  end

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;
  int unsigned iss_q[$];
  int unsigned out0_q[$];
  int unsigned out1_q[$];
  int unsigned gnt_q[$];
  int unsigned last_iss_cyc = 0;
  int unsigned done_cyc     = 0;
  int unsigned n_done0      = 0;
  bit          both_seen    = 0;
  bit          overlap_seen = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned qat(input int unsigned q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD;
  endfunction

  task automatic step();
    @(negedge clock);
    cyc++;
    if (bus.givedataout) begin
      iss_q.push_back(32'(bus.addressofdata));
      last_iss_cyc = cyc;
    end
    if (bus.out0_valid) out0_q.push_back(32'(bus.out0_data));
    if (bus.out1_valid) out1_q.push_back(32'(bus.out1_data));
    if (bus.gnt0) gnt_q.push_back(0);
    if (bus.gnt1) gnt_q.push_back(1);
    if (bus.done0) n_done0++;
    if (bus.out0_valid && bus.out1_valid) both_seen = 1;
    if (bus.done0 && bus.out0_valid) overlap_seen = 1;
  endtask

  task automatic clr();
    iss_q.delete();
    out0_q.delete();
    out1_q.delete();
    gnt_q.delete();
  endtask

  task automatic wait_gnt(input int p, input string tag);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if ((p == 0) ? bus.gnt0 : bus.gnt1) seen = 1;
    end
    check_vec(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int p, input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if ((p == 0) ? bus.done0 : bus.done1) begin
        seen = 1;
        done_cyc = cyc;
      end
    end
    check_vec(tag, 32'(seen), 32'd1);
  endtask

  task automatic peek(input logic [23:0] a, input bit bad, input string tag);
    clr();
    bus.addr1 = a;
    bus.req1  = 1'b1;
    wait_gnt(1, {tag, "_gnt"});
    bus.req1 = 1'b0;
    wait_done(1, {tag, "_done"});
    check_vec({tag, "_err1"}, 32'(bus.err1), 32'(bad));
    check_vec({tag, "_nreads"}, iss_q.size(), bad ? 0 : 1);
    check_vec({tag, "_nwords"}, out1_q.size(), bad ? 0 : 1);
    if (!bad) begin
      check_vec({tag, "_addr"}, qat(iss_q, 0), 32'(a));
      check_vec({tag, "_data"}, qat(out1_q, 0), 32'(exp_data(a)));
    end
    step();
  endtask

  initial begin
    reset            = 1'b0;
    bus.req0         = 1'b0;
    bus.len0         = '0;
    bus.req1         = 1'b0;
    bus.addr1        = '0;
    bus.datastarting = '0;
    bus.dataend      = '0;
    #12;
    check_vec("rst_gnt0", 32'(bus.gnt0), 0);
    check_vec("rst_give", 32'(bus.givedataout), 0);
    check_vec("rst_addr", 32'(bus.addressofdata), 0);
    check_vec("rst_count0", 32'(bus.count0), 0);
    check_vec("rst_done1", 32'(bus.done1), 0);
    step();
    reset = 1'b1;
    step();

    // Stream basic
    clr();
    bus.datastarting = 24'd0;
    bus.dataend      = 24'd8;
    bus.len0         = 16'd5;
    bus.req0         = 1'b1;
    wait_gnt(0, "s1_gnt");
    bus.req0 = 1'b0;
    wait_done(0, "s1_done");
    check_vec("s1_nreads", iss_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_vec("s1_addr", qat(iss_q, i), i);
      check_vec("s1_data", qat(out0_q, i), 32'(exp_data(24'(i))));
    end
    check_vec("s1_short0", 32'(bus.short0), 0);
    check_vec("s1_count0", 32'(bus.count0), 5);
    step();

    // Stall then resume
    clr();
    bus.datastarting = 24'd5;
    bus.dataend      = 24'd7;
    bus.len0         = 16'd4;
    bus.req0         = 1'b1;
    wait_gnt(0, "s2_gnt");
    bus.req0 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check_vec("s2_stalled_reads", iss_q.size(), 2);
    bus.dataend = 24'd11;
    wait_done(0, "s2_done");
    check_vec("s2_nreads", iss_q.size(), 4);
    check_vec("s2_addr3", qat(iss_q, 3), 8);
    check_vec("s2_data3", qat(out0_q, 3), 32'(exp_data(24'd8)));
    check_vec("s2_short0", 32'(bus.short0), 0);
    check_vec("s2_count0", 32'(bus.count0), 4);
    step();

    // Stall timeout
    clr();
    bus.datastarting = 24'd20;
    bus.dataend      = 24'd21;
    bus.len0         = 16'd3;
    bus.req0         = 1'b1;
    wait_gnt(0, "s3_gnt");
    bus.req0 = 1'b0;
    wait_done(0, "s3_done");
    check_vec("s3_nreads", iss_q.size(), 1);
    check_vec("s3_short0", 32'(bus.short0), 1);
    check_vec("s3_count0", 32'(bus.count0), 1);
    check_vec("s3_gap", done_cyc - last_iss_cyc, 17);
    step();

    // Peek range
    bus.datastarting = 24'd4;
    bus.dataend      = 24'd10;
    peek(24'd7, 1'b0, "p_mid");
    peek(24'd4, 1'b1, "p_head");
    peek(24'd10, 1'b1, "p_end");
    peek(24'd9, 1'b0, "p_last");
    check_vec("done_word_overlap", 32'(overlap_seen), 0);

    // Round-robin, both requests held from reset
    reset            = 1'b0;
    bus.datastarting = 24'd0;
    bus.dataend      = 24'd8;
    bus.len0         = 16'd2;
    bus.addr1        = 24'd3;
    bus.req0         = 1'b1;
    bus.req1         = 1'b1;
    step();
    clr();
    both_seen = 0;
    reset = 1'b1;
    for (int i = 0; i < 300 && gnt_q.size() < 4; i++) step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) check_vec("rr_order", qat(gnt_q, i), i % 2);
    for (int i = 0; i < 20; i++) step();
    check_vec("rr_both_valid", 32'(both_seen), 0);

    // Async reset mid-burst
    clr();
    bus.datastarting = 24'd0;
    bus.dataend      = 24'd100;
    bus.len0         = 16'd10;
    bus.req0         = 1'b1;
    for (int i = 0; i < 60 && out0_q.size() < 2; i++) step();
    check_vec("ar_two_words", out0_q.size(), 2);
    n_done0 = 0;
    #2;
    reset = 1'b0;
    #1;
    check_vec("ar_give", 32'(bus.givedataout), 0);
    check_vec("ar_out0_valid", 32'(bus.out0_valid), 0);
    check_vec("ar_count0", 32'(bus.count0), 0);
    check_vec("ar_addr", 32'(bus.addressofdata), 0);
    step();
    step();
    check_vec("ar_no_done", n_done0, 0);
    clr();
    reset = 1'b1;
    wait_gnt(0, "ar_regrant");
    bus.req0 = 1'b0;
    wait_done(0, "ar_done");
    check_vec("ar_count_after", 32'(bus.count0), 10);
    check_vec("ar_addr_first", qat(iss_q, 0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
